// File: rtl/carfield_addr_rule_table.sv
// carfield_addr_rule_table
//
// Runtime-programmable address decode table. The table holds NumRules
// [start, end) -> index rules. Software writes a shadow copy over a 32-bit
// register port. A COMMIT copies the shadow set into the active set in a single
// cycle. Lookups against the active set go through a one-stage valid/ready
// pipeline. A sticky LOCK freezes the rules and the CTRL register until reset.
//
// Optional feature macro: CARFIELD_ADDR_RULE_MISS_LOG_EN
//   defined   -> MISS_CNT / MISS_ADDR_LO / MISS_ADDR_HI are implemented
//   undefined -> those offsets read 0 and ignore writes, with no error
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   cfg_valid_i/write_i/addr_i/     register access; the response is combinational
//   wdata_i, cfg_ready_o (const 1), in the same cycle as the request
//   cfg_rdata_o, cfg_error_o
//   dec_valid_i, dec_addr_i,        lookup request
//   dec_ready_o
//   res_valid_o, res_ready_i,       registered lookup result
//   res_idx_o, res_hit_o
module carfield_addr_rule_table #(
   parameter int unsigned NumRules   = 8,
   parameter int unsigned NumSlv     = 8,
   parameter int unsigned AddrWidth  = 48,
   parameter int unsigned DefaultIdx = 0,
   parameter logic [NumRules-1:0][AddrWidth-1:0] RstStart = '0,
   parameter logic [NumRules-1:0][AddrWidth-1:0] RstEnd   = '0,
   parameter logic [NumRules-1:0][31:0]          RstIdx   = '0,
   parameter logic [NumRules-1:0]                RstEn    = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_valid_i,
   input  logic                 cfg_write_i,
   input  logic [10:0]          cfg_addr_i,
   input  logic [31:0]          cfg_wdata_i,
   output logic                 cfg_ready_o,
   output logic [31:0]          cfg_rdata_o,
   output logic                 cfg_error_o,
   input  logic                 dec_valid_i,
   input  logic [AddrWidth-1:0] dec_addr_i,
   output logic                 dec_ready_o,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [((NumSlv > 1) ? $clog2(NumSlv) : 1)-1:0] res_idx_o,
   output logic                 res_hit_o
);

   localparam int unsigned IdxW = (NumSlv > 1) ? $clog2(NumSlv) : 1;
   localparam int unsigned HiW  = AddrWidth - 32;

   localparam logic [2:0] FldStartLo = 3'd0;
   localparam logic [2:0] FldStartHi = 3'd1;
   localparam logic [2:0] FldEndLo   = 3'd2;
   localparam logic [2:0] FldEndHi   = 3'd3;
   localparam logic [2:0] FldIdx     = 3'd4;

   typedef enum logic [0:0] {StIdle, StPending} commit_state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [AddrWidth-1:0] sh_start  [NumRules];
   logic [AddrWidth-1:0] sh_end    [NumRules];
   logic [IdxW-1:0]      sh_idx    [NumRules];
   logic                 sh_en     [NumRules];
   logic [AddrWidth-1:0] act_start [NumRules];
   logic [AddrWidth-1:0] act_end   [NumRules];
   logic [IdxW-1:0]      act_idx   [NumRules];
   logic                 act_en    [NumRules];

   commit_state_e state;
   logic          locked;
   logic          pending;

   logic            res_valid;
   logic [IdxW-1:0] res_idx;
   logic            res_hit;

   // ---------------------------------------------------------------------------
   // Register address decode
   // ---------------------------------------------------------------------------
   logic       in_rules;
   logic [3:0] rule_sel;
   logic [2:0] field;
   logic       rule_ok;
   logic       is_ctrl, is_status, is_miss_cnt, is_miss_lo, is_miss_hi;
   logic       mapped;
   logic       wr;
   logic       rule_we;
   logic       ctrl_we;
   logic       miss_clr;
   logic       unused_cfg_addr;

   assign unused_cfg_addr = ^cfg_addr_i[1:0];

   assign in_rules    = (cfg_addr_i[10:9] == 2'b00);
   assign rule_sel    = cfg_addr_i[8:5];
   assign field       = cfg_addr_i[4:2];
   assign rule_ok     = in_rules && (32'(rule_sel) < NumRules) && (field <= FldIdx);
   assign is_ctrl     = (cfg_addr_i[10:2] == 9'h080);
   assign is_status   = (cfg_addr_i[10:2] == 9'h081);
   assign is_miss_cnt = (cfg_addr_i[10:2] == 9'h082);
   assign is_miss_lo  = (cfg_addr_i[10:2] == 9'h083);
   assign is_miss_hi  = (cfg_addr_i[10:2] == 9'h084);
   assign mapped      = rule_ok | is_ctrl | is_status | is_miss_cnt | is_miss_lo | is_miss_hi;

   assign wr       = cfg_valid_i & cfg_write_i;
   assign rule_we  = wr & rule_ok & ~locked & ~pending;
   assign ctrl_we  = wr & is_ctrl & ~locked;
   assign miss_clr = wr & is_miss_cnt;

   assign cfg_ready_o = 1'b1;
   assign cfg_error_o = cfg_valid_i & (~mapped
                                      | (wr & rule_ok & (locked | pending))
                                      | (wr & is_ctrl & locked));

   // ---------------------------------------------------------------------------
   // Lookup (combinational over the active set; the lowest rule index wins)
   // ---------------------------------------------------------------------------
   logic            lk_hit;
   logic [IdxW-1:0] lk_idx;

   always_comb begin
      lk_hit = 1'b0;
      lk_idx = IdxW'(DefaultIdx);
      for (int i = 0; i < int'(NumRules); i++) begin
         if (!lk_hit && act_en[i] && (act_start[i] <= dec_addr_i)
             && (dec_addr_i < act_end[i])) begin
            lk_hit = 1'b1;
            lk_idx = act_idx[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Decode pipeline
   // ---------------------------------------------------------------------------
   logic res_free;
   logic dec_fire;
   logic commit_fire;

   assign res_free    = ~res_valid | res_ready_i;
   assign dec_ready_o = ~pending & res_free;
   assign dec_fire    = dec_valid_i & dec_ready_o;
   // The swap waits for the result stage, so any result still in flight keeps
   // reflecting the set it was decoded with.
   assign commit_fire = pending & res_free;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_valid <= 1'b0;
         res_idx   <= '0;
         res_hit   <= 1'b0;
      end else if (dec_fire) begin
         res_valid <= 1'b1;
         res_idx   <= lk_idx;
         res_hit   <= lk_hit;
      end else if (res_ready_i) begin
         res_valid <= 1'b0;
      end
   end

   assign res_valid_o = res_valid;
   assign res_idx_o   = res_idx;
   assign res_hit_o   = res_hit;

   // ---------------------------------------------------------------------------
   // Commit state machine and sticky lock
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= StIdle;
         locked <= 1'b0;
      end else begin
         unique case (state)
            StIdle:    if (ctrl_we && cfg_wdata_i[0]) state <= StPending;
            StPending: if (res_free) state <= StIdle;
            default:   state <= StIdle;
         endcase
         // The lock is set on the same edge the commit is requested, and the
         // pending commit still completes afterwards.
         if (ctrl_we && cfg_wdata_i[1]) locked <= 1'b1;
      end
   end

   assign pending = (state == StPending);

   // ---------------------------------------------------------------------------
   // Shadow and active rule sets
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NumRules); i++) begin
            sh_start[i]  <= RstStart[i];
            sh_end[i]    <= RstEnd[i];
            sh_idx[i]    <= RstIdx[i][IdxW-1:0];
            sh_en[i]     <= RstEn[i];
            act_start[i] <= RstStart[i];
            act_end[i]   <= RstEnd[i];
            act_idx[i]   <= RstIdx[i][IdxW-1:0];
            act_en[i]    <= RstEn[i];
         end
      end else begin
         for (int i = 0; i < int'(NumRules); i++) begin
            if (rule_we && (rule_sel == 4'(i))) begin
               case (field)
                  FldStartLo: sh_start[i][31:0]          <= cfg_wdata_i;
                  FldStartHi: sh_start[i][AddrWidth-1:32] <= cfg_wdata_i[HiW-1:0];
                  FldEndLo:   sh_end[i][31:0]            <= cfg_wdata_i;
                  FldEndHi:   sh_end[i][AddrWidth-1:32]   <= cfg_wdata_i[HiW-1:0];
                  FldIdx: begin
                     sh_idx[i] <= cfg_wdata_i[IdxW-1:0];
                     sh_en[i]  <= cfg_wdata_i[31];
                  end
                  default: ;
               endcase
            end
            // Rule writes are refused while pending, so the copy never races them.
            if (commit_fire) begin
               act_start[i] <= sh_start[i];
               act_end[i]   <= sh_end[i];
               act_idx[i]   <= sh_idx[i];
               act_en[i]    <= sh_en[i];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Miss logging
   // ---------------------------------------------------------------------------
   logic [31:0] miss_cnt_rd;
   logic [31:0] miss_lo_rd;
   logic [31:0] miss_hi_rd;

`ifdef CARFIELD_ADDR_RULE_MISS_LOG_EN
   logic [31:0]          miss_cnt;
   logic [AddrWidth-1:0] miss_addr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         miss_cnt  <= '0;
         miss_addr <= '0;
      end else begin
         // A clear beats a miss counted on the same edge.
         if (miss_clr) begin
            miss_cnt <= '0;
         end else if (dec_fire && !lk_hit && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
         if (dec_fire && !lk_hit) miss_addr <= dec_addr_i;
      end
   end

   assign miss_cnt_rd = miss_cnt;
   assign miss_lo_rd  = miss_addr[31:0];
   assign miss_hi_rd  = 32'(miss_addr[AddrWidth-1:32]);
`else
   logic unused_miss_clr;
   assign unused_miss_clr = miss_clr;
   assign miss_cnt_rd     = '0;
   assign miss_lo_rd      = '0;
   assign miss_hi_rd      = '0;
`endif

   // ---------------------------------------------------------------------------
   // Read data mux (CTRL bits are write-only and read back as 0)
   // ---------------------------------------------------------------------------
   always_comb begin
      cfg_rdata_o = '0;
      for (int i = 0; i < int'(NumRules); i++) begin
         if (rule_ok && (rule_sel == 4'(i))) begin
            case (field)
               FldStartLo: cfg_rdata_o = sh_start[i][31:0];
               FldStartHi: cfg_rdata_o = 32'(sh_start[i][AddrWidth-1:32]);
               FldEndLo:   cfg_rdata_o = sh_end[i][31:0];
               FldEndHi:   cfg_rdata_o = 32'(sh_end[i][AddrWidth-1:32]);
               FldIdx: begin
                  cfg_rdata_o     = 32'(sh_idx[i]);
                  cfg_rdata_o[31] = sh_en[i];
               end
               default: ;
            endcase
         end
      end
      if (is_status)   cfg_rdata_o = {30'd0, locked, pending};
      if (is_miss_cnt) cfg_rdata_o = miss_cnt_rd;
      if (is_miss_lo)  cfg_rdata_o = miss_lo_rd;
      if (is_miss_hi)  cfg_rdata_o = miss_hi_rd;
   end

endmodule

// File: tb/tb_carfield_addr_rule_table.sv
// Directed bench for carfield_addr_rule_table. A scoreboard queue receives the
// expected lookup results when each request is accepted. Each result is
// compared when the DUT presents it.
module tb_carfield_addr_rule_table;

   localparam int unsigned NumRules   = 8;
   localparam int unsigned NumSlv     = 8;
   localparam int unsigned AddrWidth  = 48;
   localparam int unsigned DefaultIdx = 5;
   localparam logic [NumRules-1:0][AddrWidth-1:0] RstStart =
      {{7{48'h0}}, 48'h0000_7800_0000};
   localparam logic [NumRules-1:0][AddrWidth-1:0] RstEnd =
      {{7{48'h0}}, 48'h0000_7820_0000};

`ifdef CARFIELD_ADDR_RULE_MISS_LOG_EN
   localparam bit MissLog = 1'b1;
`else
   localparam bit MissLog = 1'b0;
`endif

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 cfg_valid = 1'b0;
   logic                 cfg_write = 1'b0;
   logic [10:0]          cfg_addr = '0;
   logic [31:0]          cfg_wdata = '0;
   logic                 cfg_ready;
   logic [31:0]          cfg_rdata;
   logic                 cfg_error;
   logic                 dec_valid = 1'b0;
   logic [AddrWidth-1:0] dec_addr = '0;
   logic                 dec_ready;
   logic                 res_valid;
   logic                 res_ready = 1'b1;
   logic [2:0]           res_idx;
   logic                 res_hit;

   always #5 clk_i = ~clk_i;

   carfield_addr_rule_table #(
      .NumRules   (NumRules),
      .NumSlv     (NumSlv),
      .AddrWidth  (AddrWidth),
      .DefaultIdx (DefaultIdx),
      .RstStart   (RstStart),
      .RstEnd     (RstEnd),
      .RstIdx     ('0),
      .RstEn      (8'h01)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cfg_valid_i (cfg_valid),
      .cfg_write_i (cfg_write),
      .cfg_addr_i  (cfg_addr),
      .cfg_wdata_i (cfg_wdata),
      .cfg_ready_o (cfg_ready),
      .cfg_rdata_o (cfg_rdata),
      .cfg_error_o (cfg_error),
      .dec_valid_i (dec_valid),
      .dec_addr_i  (dec_addr),
      .dec_ready_o (dec_ready),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_idx_o   (res_idx),
      .res_hit_o   (res_hit)
   );

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } res_t;

   res_t        sb[$];
   int unsigned passed = 0;
   int unsigned total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // All tasks start and end on a falling edge with the request inputs idle.
   task automatic cfg_wr(input logic [10:0] a, input logic [31:0] d, input logic err,
                         input string tag);
      cfg_valid = 1'b1;
      cfg_write = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      #1 chk({tag, ".err"}, 64'(cfg_error), 64'(err));
      @(negedge clk_i);
      cfg_valid = 1'b0;
      cfg_write = 1'b0;
   endtask

   task automatic cfg_rd(input logic [10:0] a, input logic [31:0] exp, input logic err,
                         input string tag);
      cfg_valid = 1'b1;
      cfg_write = 1'b0;
      cfg_addr  = a;
      #1 chk({tag, ".err"}, 64'(cfg_error), 64'(err));
      if (!err) chk(tag, 64'(cfg_rdata), 64'(exp));
      @(negedge clk_i);
      cfg_valid = 1'b0;
   endtask

   task automatic collect(input string tag);
      res_t e;
      int   n = 0;
      while (!res_valid && n < 5) begin
         @(negedge clk_i);
         n++;
      end
      chk({tag, ".valid"}, 64'(res_valid), 64'(1));
      chk({tag, ".sb"}, 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, ".hit"}, 64'(res_hit), 64'(e.hit));
         chk({tag, ".idx"}, 64'(res_idx), 64'(e.idx));
      end
      res_ready = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic lookup(input logic [AddrWidth-1:0] a, input logic eh, input logic [2:0] ei,
                         input string tag);
      dec_valid = 1'b1;
      dec_addr  = a;
      res_ready = 1'b1;
      #1 chk({tag, ".rdy"}, 64'(dec_ready), 64'(1));
      if (dec_ready) sb.push_back('{hit: eh, idx: ei});
      @(negedge clk_i);
      dec_valid = 1'b0;
      collect(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      // Reset values
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rst.res_valid", 64'(res_valid), 64'(0));
      chk("rst.res_hit", 64'(res_hit), 64'(0));
      chk("rst.res_idx", 64'(res_idx), 64'(0));
      chk("rst.cfg_ready", 64'(cfg_ready), 64'(1));
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("rst.dec_ready", 64'(dec_ready), 64'(1));
      cfg_rd(11'h204, 32'h0, 1'b0, "rst.status");
      cfg_rd(11'h000, 32'h7800_0000, 1'b0, "rst.r0_start");
      cfg_rd(11'h008, 32'h7820_0000, 1'b0, "rst.r0_end");
      cfg_rd(11'h010, 32'h8000_0000, 1'b0, "rst.r0_idx");

      // Reset rule 0: the end address is exclusive and the start is inclusive
      lookup(48'h0000_781F_FFFF, 1'b1, 3'd0, "r0.in");
      lookup(48'h0000_7820_0000, 1'b0, 3'd5, "r0.end");
      lookup(48'h0000_7800_0000, 1'b1, 3'd0, "r0.start");
      lookup(48'h0000_77FF_FFFF, 1'b0, 3'd5, "r0.below");

      // Address map errors and START_HI width
      cfg_rd(11'h100, 32'h0, 1'b1, "err.rule8");
      cfg_rd(11'h014, 32'h0, 1'b1, "err.field5");
      cfg_rd(11'h300, 32'h0, 1'b1, "err.unmapped");
      cfg_rd(11'h200, 32'h0, 1'b0, "ctrl.rd0");
      cfg_wr(11'h0E4, 32'hFFFF_FFFF, 1'b0, "r7.hi_wr");
      cfg_rd(11'h0E4, 32'h0000_FFFF, 1'b0, "r7.hi_rd");
      cfg_wr(11'h0E4, 32'h0, 1'b0, "r7.hi_clr");

      // Rule 1 is programmed without a commit, so the active set is unchanged
      cfg_wr(11'h020, 32'h5000_0000, 1'b0, "r1.start");
      cfg_wr(11'h024, 32'h0, 1'b0, "r1.start_hi");
      cfg_wr(11'h028, 32'h5080_0000, 1'b0, "r1.end");
      cfg_wr(11'h02C, 32'h0, 1'b0, "r1.end_hi");
      cfg_wr(11'h030, 32'h8000_0007, 1'b0, "r1.idx");
      cfg_rd(11'h030, 32'h8000_0007, 1'b0, "r1.idx_rd");
      lookup(48'h0000_5000_0010, 1'b0, 3'd5, "r1.precommit");
      cfg_wr(11'h200, 32'h1, 1'b0, "r1.commit");
      cfg_rd(11'h204, 32'h1, 1'b0, "r1.pending");
      lookup(48'h0000_5000_0010, 1'b1, 3'd7, "r1.postcommit");

      // Overlap: rule 2 -> 3, rule 5 -> 4, so the lowest index wins
      cfg_wr(11'h040, 32'h2000_0000, 1'b0, "r2.start");
      cfg_wr(11'h048, 32'h2000_2000, 1'b0, "r2.end");
      cfg_wr(11'h050, 32'h8000_0003, 1'b0, "r2.idx");
      cfg_wr(11'h0A0, 32'h2000_1000, 1'b0, "r5.start");
      cfg_wr(11'h0A8, 32'h2000_3000, 1'b0, "r5.end");
      cfg_wr(11'h0B0, 32'h8000_0004, 1'b0, "r5.idx");
      cfg_wr(11'h200, 32'h1, 1'b0, "ovl.commit");
      // The commit is still pending here, so the rule write is refused
      cfg_wr(11'h0C0, 32'h1234, 1'b1, "pend.wr");
      cfg_rd(11'h0C0, 32'h0, 1'b0, "pend.unchanged");
      lookup(48'h0000_2000_1000, 1'b1, 3'd3, "ovl.both");
      lookup(48'h0000_2000_2800, 1'b1, 3'd4, "ovl.r5only");

      // Commit while a result is held: the held result keeps the old mapping
      cfg_wr(11'h030, 32'h8000_0002, 1'b0, "held.r1idx");
      res_ready = 1'b0;
      dec_valid = 1'b1;
      dec_addr  = 48'h0000_5000_0010;
      #1 chk("held.rdy", 64'(dec_ready), 64'(1));
      if (dec_ready) sb.push_back('{hit: 1'b1, idx: 3'd7});
      @(negedge clk_i);
      dec_valid = 1'b0;
      cfg_wr(11'h200, 32'h1, 1'b0, "held.commit");
      chk("held.dec_ready", 64'(dec_ready), 64'(0));
      cfg_rd(11'h204, 32'h1, 1'b0, "held.status");
      chk("held.still_valid", 64'(res_valid), 64'(1));
      collect("held.res");
      cfg_rd(11'h204, 32'h0, 1'b0, "held.status2");
      lookup(48'h0000_5000_0010, 1'b1, 3'd2, "held.newmap");

      // Lock: rule and CTRL writes are refused and decoding is unchanged
      cfg_wr(11'h200, 32'h2, 1'b0, "lock.set");
      cfg_rd(11'h204, 32'h2, 1'b0, "lock.status");
      cfg_wr(11'h000, 32'h1000_0000, 1'b1, "lock.rule_wr");
      cfg_wr(11'h200, 32'h1, 1'b1, "lock.commit");
      cfg_rd(11'h000, 32'h7800_0000, 1'b0, "lock.r0_start");
      cfg_rd(11'h204, 32'h2, 1'b0, "lock.status2");
      lookup(48'h0000_781F_FFFF, 1'b1, 3'd0, "lock.decode");

      // Miss log: a clear is allowed while locked
      cfg_wr(11'h208, 32'h0, 1'b0, "miss.clr");
      cfg_rd(11'h208, 32'h0, 1'b0, "miss.cnt0");
      lookup(48'h0001_2345_6780, 1'b0, 3'd5, "miss1");
      lookup(48'h0000_9000_0000, 1'b0, 3'd5, "miss2");
      lookup(48'hABCD_1234_5678, 1'b0, 3'd5, "miss3");
      cfg_rd(11'h208, MissLog ? 32'd3 : 32'd0, 1'b0, "miss.cnt3");
      cfg_rd(11'h20C, MissLog ? 32'h1234_5678 : 32'd0, 1'b0, "miss.addr_lo");
      cfg_rd(11'h210, MissLog ? 32'h0000_ABCD : 32'd0, 1'b0, "miss.addr_hi");
      // A clear on the same edge as a miss wins
      dec_valid = 1'b1;
      dec_addr  = 48'h0000_9100_0000;
      res_ready = 1'b1;
      cfg_valid = 1'b1;
      cfg_write = 1'b1;
      cfg_addr  = 11'h208;
      cfg_wdata = 32'h0;
      #1 chk("miss.clr_same.rdy", 64'(dec_ready), 64'(1));
      chk("miss.clr_same.err", 64'(cfg_error), 64'(0));
      if (dec_ready) sb.push_back('{hit: 1'b0, idx: 3'd5});
      @(negedge clk_i);
      dec_valid = 1'b0;
      cfg_valid = 1'b0;
      cfg_write = 1'b0;
      collect("miss.clr_same");
      cfg_rd(11'h208, 32'h0, 1'b0, "miss.cnt_after_clr");
      lookup(48'h0000_9200_0000, 1'b0, 3'd5, "miss4");
      cfg_rd(11'h208, MissLog ? 32'd1 : 32'd0, 1'b0, "miss.cnt1");

      // Asynchronous reset during a held lookup drops the result and the commits
      res_ready = 1'b0;
      dec_valid = 1'b1;
      dec_addr  = 48'h0000_5000_0010;
      @(negedge clk_i);
      dec_valid = 1'b0;
      #2 rst_ni = 1'b0;
      #1 chk("arst.res_valid", 64'(res_valid), 64'(0));
      chk("arst.res_hit", 64'(res_hit), 64'(0));
      chk("arst.res_idx", 64'(res_idx), 64'(0));
      sb.delete();
      @(negedge clk_i);
      rst_ni    = 1'b1;
      res_ready = 1'b1;
      @(negedge clk_i);
      cfg_rd(11'h204, 32'h0, 1'b0, "arst.status");
      cfg_rd(11'h030, 32'h0, 1'b0, "arst.r1_idx");
      lookup(48'h0000_5000_0010, 1'b0, 3'd5, "arst.r1_gone");
      lookup(48'h0000_7810_0000, 1'b1, 3'd0, "arst.r0_back");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/carfield_addr_rule_table.md
# carfield_addr_rule_table

- Runtime-programmable address-decode rule table: a successor to the static AXI/APB/reg address maps.
- Holds `NumRules` start/end/index rules: a shadow set written over a 32-bit register interface and an active set used for decoding.
- Performs a one-cycle pipelined lookup of a request address to a slave index, with atomic commit, sticky lock and optional miss logging.
- Sits in front of the Carfield external AXI demux select path, so the region map can be changed at boot.

## Interface
- `NumRules`, 8: number of rules, 1..16.
- `NumSlv`, 8: number of slave indices; index width `IdxW = max(1, $clog2(NumSlv))`.
- `AddrWidth`, 48: decode address width, 33..64.
- `DefaultIdx`, 0: index output on a miss.
- `RstStart` / `RstEnd` / `RstIdx` / `RstEn`, all zero: per-rule reset values, arrays of `NumRules`.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `cfg_valid_i`, in, 1: register access request.
- `cfg_write_i`, in, 1: 1 = write, 0 = read.
- `cfg_addr_i`, in, 11: byte offset; bits [1:0] are ignored.
- `cfg_wdata_i`, in, 32: write data.
- `cfg_ready_o`, out, 1: access accepted; always 1.
- `cfg_rdata_o`, out, 32: read data, combinational in the same cycle as the request.
- `cfg_error_o`, out, 1: access error, same cycle as the request.
- `dec_valid_i`, in, 1: lookup request.
- `dec_addr_i`, in, AddrWidth: address to decode.
- `dec_ready_o`, out, 1: lookup accepted.
- `res_valid_o`, out, 1: result valid.
- `res_ready_i`, in, 1: result consumed.
- `res_idx_o`, out, IdxW: matched slave index.
- `res_hit_o`, out, 1: 1 = a rule matched.

## Operation
- **Register map**
  - Rule i lives at `i*0x20`.
  - 0x00 START_LO and 0x04 START_HI: START_HI keeps bits above `AddrWidth` at 0.
  - 0x08 END_LO and 0x0C END_HI.
  - 0x10 IDX: bits [IdxW-1:0] hold the index; bit 31 is EN.
  - 0x200 CTRL: bit0 COMMIT and bit1 LOCK are write-only and read 0.
  - 0x204 STATUS: bit0 PENDING, bit1 LOCKED.
  - 0x208 MISS_CNT, 0x20C MISS_ADDR_LO, 0x210 MISS_ADDR_HI.
- **Cfg reads and writes**
  - Rule offsets read and write the shadow set. Rule offsets at or above `NumRules` and unmapped offsets set `cfg_error_o`.
  - A write to a rule or to CTRL while LOCKED: error, no effect.
  - A write to a rule while PENDING: error, no effect.
  - A write to MISS_CNT clears the count, locked or not.
- **Match rule**
  - Rule i matches when EN, `start <= addr` and `addr < end`, all unsigned over `AddrWidth` bits.
  - A rule with `start >= end` never matches.
  - If several rules match, the lowest i wins.
- **Commit state machine**
  - IDLE: a write with COMMIT=1 moves to PENDING.
  - PENDING: `dec_ready_o` = 0. When the result stage is empty or draining (`!res_valid_o || res_ready_i`), copy shadow to active in one cycle and return to IDLE.
  - A result in flight was decoded with the old set; the new set applies only to requests accepted afterwards.
- **Lock**
  - LOCK=1 sets LOCKED, which is sticky until reset.
  - COMMIT and LOCK in the same write: the commit is taken, then lock takes effect.
- **Decode pipeline**
  - `dec_ready_o = !PENDING && (!res_valid_o || res_ready_i)`.
  - On `dec_valid_i && dec_ready_o`, register idx/hit, and set `res_valid_o` on the next cycle.
  - Results are held stable while `res_valid_o && !res_ready_i`.
- **Miss**: `res_hit_o` = 0 and `res_idx_o` = DefaultIdx.

## Timing
- Decode latency: 1 cycle from acceptance; full throughput of 1 lookup/cycle while `res_ready_i` = 1.
- Cfg accesses take effect on the same edge and are never back-pressured.
- Commit completes at the earliest 1 cycle after the COMMIT write; STATUS.PENDING reads 1 during that cycle.
- **Reset values**
  - `res_valid_o` = 0, `res_idx_o` = 0, `res_hit_o` = 0.
  - Both shadow and active sets = `Rst*` parameters.
  - PENDING = 0, LOCKED = 0, miss registers = 0.
- Asynchronous reset mid-commit or mid-lookup discards the operation; the active set returns to the `Rst*` values.
- **Miss counter**
  - Updated at acceptance of a missed lookup and saturates at 0xFFFF_FFFF.
  - A clear in the same cycle as a miss wins; the count becomes 0.
  - MISS_ADDR records the most recent miss address.

## Configuration
- `CARFIELD_ADDR_RULE_MISS_LOG_EN`
  - Defined: MISS_CNT and MISS_ADDR registers are implemented as above.
  - Undefined: no counter or capture flops; the three offsets read 0, writes are ignored, no error.

## Test plan
- Reset with RstStart[0]=0x7800_0000, RstEnd[0]=0x7820_0000, RstIdx[0]=0, RstEn[0]=1; lookup 0x781F_FFFF -> next cycle hit=1, idx=0. Lookup 0x7820_0000 -> hit=0, idx=DefaultIdx.
- Program rule 1 as [0x5000_0000, 0x5080_0000) with idx=7 and EN, without COMMIT; lookup 0x5000_0010 -> miss. Write COMMIT and repeat the lookup -> hit=1, idx=7.
- Overlapping rules 2 (idx 3) and 5 (idx 4), both covering 0x2000_1000 -> idx=3.
- Hold `res_ready_i` = 0 with a result pending, then write COMMIT -> PENDING=1 and `dec_ready_o`=0. Release `res_ready_i` -> the held result shows the old mapping and the swap happens on that edge.
- Write LOCK, then write rule 0 START_LO and COMMIT -> both give `cfg_error_o`=1 and decoding is unchanged. STATUS reads 0x2.
- Macro defined: 3 misses -> MISS_CNT=3 and MISS_ADDR = the last address; a clear in the same cycle as a miss -> 0. Macro undefined: all three offsets read 0.
